// File: rtl/gemm_tile_scheduler.sv
// gemm_tile_scheduler: walks an M x K x N GEMM as W x W tiles (nt outer, mt middle, kt inner)
// and programs control_unit over its CSR port. Define TILE_SCHED_PERF_EN for perf_cycles/perf_tiles.
//
// state    | meaning
// IDLE     | waiting for start, cfg latched on accept
// CHECK    | reject zero dimensions, clear tile indices
// CALC     | register tile sizes and buffer/DDR addresses
// PROG     | 11 CSR writes describing the tile
// KICK     | write 1 to control_unit CTRL
// GAP      | one idle cycle, arm the timeout
// WAIT     | poll STATUS until the done bit or timeout
// NEXT     | advance kt, mt, nt
// FINISH   | one-cycle done pulse
module gemm_tile_scheduler #(
  parameter int          SYSTOLIC_ARRAY_WIDTH = 16,
  parameter int          ADDR_WIDTH           = 10,
  parameter int          CSR_ADDR_WIDTH       = 8,
  parameter int          DIM_WIDTH            = 16,
  parameter logic [31:0] DDR_TILE_STRIDE      = 32'h400,
  parameter int          TIMEOUT_CYCLES       = 65535
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DIM_WIDTH-1:0]      cfg_m,
  input  logic [DIM_WIDTH-1:0]      cfg_k,
  input  logic [DIM_WIDTH-1:0]      cfg_n,
  input  logic [ADDR_WIDTH-1:0]     cfg_addr_a,
  input  logic [ADDR_WIDTH-1:0]     cfg_addr_b,
  input  logic [ADDR_WIDTH-1:0]     cfg_addr_c,
  input  logic [ADDR_WIDTH-1:0]     cfg_addr_d,
  input  logic [31:0]               cfg_addr_ddr,
  input  logic [2:0]                cfg_vpu_mode,
  input  logic [15:0]               cfg_lat_c,
  input  logic [15:0]               cfg_lat_d,
  output logic                      busy,
  output logic                      done,
  output logic [1:0]                err,
  output logic [CSR_ADDR_WIDTH-1:0] cu_csr_addr,
  output logic                      cu_csr_wr_en,
  output logic [31:0]               cu_csr_wr_data,
  output logic                      cu_csr_rd_en,
  input  logic [31:0]               cu_csr_rd_data
`ifdef TILE_SCHED_PERF_EN
  ,
  output logic [31:0]               perf_cycles,
  output logic [15:0]               perf_tiles
`endif
);

  localparam int            LOG2W    = $clog2(SYSTOLIC_ARRAY_WIDTH);
  localparam int            TW       = DIM_WIDTH + 1;
  localparam logic [TW-1:0] W_T      = TW'(SYSTOLIC_ARRAY_WIDTH);
  localparam logic [TW-1:0] ONE_T    = TW'(1);
  localparam logic [31:0]   TMO_LOAD = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_CALC, S_PROG, S_KICK, S_GAP, S_WAIT, S_NEXT, S_FINISH
  } state_t;

  state_t state_q, state_d;

  logic [DIM_WIDTH-1:0]  m_q, k_q, n_q;
  logic [ADDR_WIDTH-1:0] a_q, b_q, c_q, d_q;
  logic [31:0]           ddr_q;
  logic [2:0]            vpu_q;
  logic [15:0]           lat_c_q, lat_d_q;
  logic [TW-1:0]         mt_q, kt_q, nt_q;
  logic [TW-1:0]         tile_m_q, tile_k_q, tile_n_q;
  logic [ADDR_WIDTH-1:0] addr_a_q, addr_b_q, addr_c_q, addr_d_q;
  logic [31:0]           ddr_tile_q;
  logic [3:0]            prog_idx_q;
  logic [31:0]           tmo_q;
  logic [1:0]            err_q;

  logic [TW-1:0]         t_m, t_k, t_n, rem_m, rem_k, rem_n;
  logic [31:0]           idx_d;
  logic [ADDR_WIDTH-1:0] addr_a_n, addr_b_n, addr_d_n, addr_c_n;
  logic                  zero_dim, kt_last, mt_last, nt_last;
  logic [2:0]            vpu_eff;
  logic [CSR_ADDR_WIDTH-1:0] prog_addr;
  logic [31:0]           prog_data;
  logic                  unused_rd_bits;

  assign t_m   = ({1'b0, m_q} + W_T - ONE_T) >> LOG2W;
  assign t_k   = ({1'b0, k_q} + W_T - ONE_T) >> LOG2W;
  assign t_n   = ({1'b0, n_q} + W_T - ONE_T) >> LOG2W;
  assign rem_m = {1'b0, m_q} - (mt_q << LOG2W);
  assign rem_k = {1'b0, k_q} - (kt_q << LOG2W);
  assign rem_n = {1'b0, n_q} - (nt_q << LOG2W);

  // Index arithmetic in 32 bits so truncation to ADDR_WIDTH is a true modulo.
  assign idx_d    = 32'(mt_q) * 32'(t_n) + 32'(nt_q);
  assign addr_a_n = a_q + (ADDR_WIDTH'(32'(mt_q) * 32'(t_k) + 32'(kt_q)) << LOG2W);
  assign addr_b_n = b_q + (ADDR_WIDTH'(32'(kt_q) * 32'(t_n) + 32'(nt_q)) << LOG2W);
  assign addr_d_n = d_q + (ADDR_WIDTH'(idx_d) << LOG2W);
  assign addr_c_n = (kt_q == '0) ? c_q + (ADDR_WIDTH'(idx_d) << LOG2W) : addr_d_n;

  assign zero_dim = (m_q == '0) || (k_q == '0) || (n_q == '0);
  assign kt_last  = (kt_q == t_k - ONE_T);
  assign mt_last  = (mt_q == t_m - ONE_T);
  assign nt_last  = (nt_q == t_n - ONE_T);
  assign vpu_eff  = kt_last ? vpu_q : 3'd0;
  assign err      = err_q;
  assign unused_rd_bits = ^{cu_csr_rd_data[31:2], cu_csr_rd_data[0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_CHECK;
      S_CHECK:  state_d = zero_dim ? S_FINISH : S_CALC;
      S_CALC:   state_d = S_PROG;
      S_PROG:   if (prog_idx_q == 4'd10) state_d = S_KICK;
      S_KICK:   state_d = S_GAP;
      S_GAP:    state_d = S_WAIT;
      S_WAIT: begin
        if (cu_csr_rd_data[1]) state_d = S_NEXT;
        else if (tmo_q == '0)  state_d = S_FINISH;
      end
      S_NEXT:   state_d = (kt_last && mt_last && nt_last) ? S_FINISH : S_CALC;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q <= '0; k_q <= '0; n_q <= '0;
      a_q <= '0; b_q <= '0; c_q <= '0; d_q <= '0;
      ddr_q <= '0; vpu_q <= '0; lat_c_q <= '0; lat_d_q <= '0;
      mt_q <= '0; kt_q <= '0; nt_q <= '0;
      tile_m_q <= '0; tile_k_q <= '0; tile_n_q <= '0;
      addr_a_q <= '0; addr_b_q <= '0; addr_c_q <= '0; addr_d_q <= '0;
      ddr_tile_q <= '0; prog_idx_q <= '0; tmo_q <= '0; err_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          m_q <= cfg_m; k_q <= cfg_k; n_q <= cfg_n;
          a_q <= cfg_addr_a; b_q <= cfg_addr_b; c_q <= cfg_addr_c; d_q <= cfg_addr_d;
          ddr_q <= cfg_addr_ddr; vpu_q <= cfg_vpu_mode;
          lat_c_q <= cfg_lat_c; lat_d_q <= cfg_lat_d;
          err_q <= '0;
        end
        S_CHECK: begin
          mt_q <= '0; kt_q <= '0; nt_q <= '0;
          if (zero_dim) err_q[0] <= 1'b1;
        end
        S_CALC: begin
          tile_m_q   <= (rem_m > W_T) ? W_T : rem_m;
          tile_k_q   <= (rem_k > W_T) ? W_T : rem_k;
          tile_n_q   <= (rem_n > W_T) ? W_T : rem_n;
          addr_a_q   <= addr_a_n;
          addr_b_q   <= addr_b_n;
          addr_c_q   <= addr_c_n;
          addr_d_q   <= addr_d_n;
          ddr_tile_q <= ddr_q + idx_d * DDR_TILE_STRIDE;
          prog_idx_q <= '0;
        end
        S_PROG: prog_idx_q <= prog_idx_q + 4'd1;
        S_GAP:  tmo_q <= TMO_LOAD;
        S_WAIT: if (!cu_csr_rd_data[1]) begin
          if (tmo_q == '0) err_q[1] <= 1'b1;
          else             tmo_q <= tmo_q - 32'd1;
        end
        S_NEXT: begin
          if (kt_last) begin
            kt_q <= '0;
            if (mt_last) begin
              mt_q <= '0;
              nt_q <= nt_q + ONE_T;
            end else begin
              mt_q <= mt_q + ONE_T;
            end
          end else begin
            kt_q <= kt_q + ONE_T;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    prog_addr = '0;
    prog_data = '0;
    case (prog_idx_q)
      4'd0:  begin prog_addr = CSR_ADDR_WIDTH'(8'h10); prog_data = 32'(tile_m_q);       end
      4'd1:  begin prog_addr = CSR_ADDR_WIDTH'(8'h14); prog_data = 32'(tile_k_q);       end
      4'd2:  begin prog_addr = CSR_ADDR_WIDTH'(8'h18); prog_data = 32'(tile_n_q);       end
      4'd3:  begin prog_addr = CSR_ADDR_WIDTH'(8'h20); prog_data = 32'(addr_a_q);       end
      4'd4:  begin prog_addr = CSR_ADDR_WIDTH'(8'h24); prog_data = 32'(addr_b_q);       end
      4'd5:  begin prog_addr = CSR_ADDR_WIDTH'(8'h28); prog_data = 32'(addr_c_q);       end
      4'd6:  begin prog_addr = CSR_ADDR_WIDTH'(8'h2C); prog_data = 32'(addr_d_q);       end
      4'd7:  begin prog_addr = CSR_ADDR_WIDTH'(8'h30); prog_data = ddr_tile_q;          end
      4'd8:  begin prog_addr = CSR_ADDR_WIDTH'(8'h34); prog_data = {29'd0, vpu_eff};    end
      4'd9:  begin prog_addr = CSR_ADDR_WIDTH'(8'h38); prog_data = {16'd0, lat_c_q};    end
      4'd10: begin prog_addr = CSR_ADDR_WIDTH'(8'h3C); prog_data = {16'd0, lat_d_q};    end
      default: ;
    endcase
  end

  always_comb begin
    busy           = 1'b0;
    done           = 1'b0;
    cu_csr_addr    = '0;
    cu_csr_wr_en   = 1'b0;
    cu_csr_wr_data = '0;
    cu_csr_rd_en   = 1'b0;
    case (state_q)
      S_CHECK, S_CALC, S_GAP, S_NEXT: busy = 1'b1;
      S_PROG: begin
        busy           = 1'b1;
        cu_csr_wr_en   = 1'b1;
        cu_csr_addr    = prog_addr;
        cu_csr_wr_data = prog_data;
      end
      S_KICK: begin
        busy           = 1'b1;
        cu_csr_wr_en   = 1'b1;
        cu_csr_wr_data = 32'h1;
      end
      S_WAIT: begin
        busy         = 1'b1;
        cu_csr_rd_en = 1'b1;
        cu_csr_addr  = CSR_ADDR_WIDTH'(8'h04);
      end
      S_FINISH: done = 1'b1;
      default: ;
    endcase
  end

`ifdef TILE_SCHED_PERF_EN
  logic [31:0] perf_cycles_q;
  logic [15:0] perf_tiles_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cycles_q <= '0;
      perf_tiles_q  <= '0;
    end else if (state_q == S_IDLE && start) begin
      perf_cycles_q <= '0;
      perf_tiles_q  <= '0;
    end else begin
      if (state_q != S_IDLE && perf_cycles_q != '1) perf_cycles_q <= perf_cycles_q + 32'd1;
      if (state_q == S_NEXT) perf_tiles_q <= perf_tiles_q + 16'd1;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_tiles  = perf_tiles_q;
`endif

endmodule

// File: tb/tb_gemm_tile_scheduler.sv
// Directed bench for gemm_tile_scheduler with W=4, TIMEOUT_CYCLES=100 and a
// control_unit stand-in that pulses STATUS bit1 a fixed number of cycles after KICK.
module tb_gemm_tile_scheduler;
  localparam int W   = 4;
  localparam int AW  = 10;
  localparam int CAW = 8;
  localparam int DW  = 16;
  localparam int TMO = 100;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [DW-1:0]  cfg_m, cfg_k, cfg_n;
  logic [AW-1:0]  cfg_addr_a, cfg_addr_b, cfg_addr_c, cfg_addr_d;
  logic [31:0]    cfg_addr_ddr;
  logic [2:0]     cfg_vpu_mode;
  logic [15:0]    cfg_lat_c, cfg_lat_d;
  logic           busy, done;
  logic [1:0]     err;
  logic [CAW-1:0] cu_csr_addr;
  logic           cu_csr_wr_en, cu_csr_rd_en;
  logic [31:0]    cu_csr_wr_data, cu_csr_rd_data;

  gemm_tile_scheduler #(
    .SYSTOLIC_ARRAY_WIDTH(W), .ADDR_WIDTH(AW), .CSR_ADDR_WIDTH(CAW),
    .DIM_WIDTH(DW), .DDR_TILE_STRIDE(32'h400), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_n(cfg_n),
    .cfg_addr_a(cfg_addr_a), .cfg_addr_b(cfg_addr_b),
    .cfg_addr_c(cfg_addr_c), .cfg_addr_d(cfg_addr_d),
    .cfg_addr_ddr(cfg_addr_ddr), .cfg_vpu_mode(cfg_vpu_mode),
    .cfg_lat_c(cfg_lat_c), .cfg_lat_d(cfg_lat_d),
    .busy(busy), .done(done), .err(err),
    .cu_csr_addr(cu_csr_addr), .cu_csr_wr_en(cu_csr_wr_en),
    .cu_csr_wr_data(cu_csr_wr_data), .cu_csr_rd_en(cu_csr_rd_en),
    .cu_csr_rd_data(cu_csr_rd_data)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Observers and control_unit stand-in, all on the falling edge.
  logic [7:0]  log_addr[$];
  logic [31:0] log_data[$];
  int          done_cnt = 0;
  int          overlap  = 0;
  int          resp_lat = 20;
  int          resp_cnt = 0;

  assign cu_csr_rd_data = (resp_cnt == 1) ? 32'h2 : 32'h0;

  always @(negedge clk) begin
    if (cu_csr_wr_en) begin
      log_addr.push_back(cu_csr_addr);
      log_data.push_back(cu_csr_wr_data);
    end
    if (cu_csr_wr_en && cu_csr_rd_en) overlap++;
    if (done) done_cnt++;
    if (rst) resp_cnt = 0;
    else if (cu_csr_wr_en && cu_csr_addr == 8'h00 && cu_csr_wr_data == 32'h1 && resp_lat > 0)
      resp_cnt = resp_lat;
    else if (resp_cnt > 0) resp_cnt = resp_cnt - 1;
  end

  function automatic logic [7:0] exp_reg(input int i);
    case (i)
      0: return 8'h10;  1: return 8'h14;  2: return 8'h18;  3: return 8'h20;
      4: return 8'h24;  5: return 8'h28;  6: return 8'h2C;  7: return 8'h30;
      8: return 8'h34;  9: return 8'h38; 10: return 8'h3C;
      default: return 8'h00;
    endcase
  endfunction

  // Checks the 11 programming writes plus KICK of one tile starting at log entry base.
  task automatic chk_tile(input string tag, input int base,
                          input int tm, input int tk, input int tn,
                          input int a, input int b, input int c, input int d,
                          input logic [31:0] ddr, input int vpu);
    logic [31:0] e[12];
    e[0] = tm; e[1] = tk; e[2] = tn; e[3] = a; e[4] = b; e[5] = c; e[6] = d;
    e[7] = ddr; e[8] = vpu; e[9] = 32'(cfg_lat_c); e[10] = 32'(cfg_lat_d); e[11] = 32'h1;
    chk({tag, "_present"}, 32'(log_addr.size() >= base + 12), 32'h1);
    if (log_addr.size() >= base + 12) begin
      for (int i = 0; i < 12; i++) begin
        chk($sformatf("%s_addr%0d", tag, i), 32'(log_addr[base+i]), 32'(exp_reg(i)));
        chk($sformatf("%s_data%0d", tag, i), log_data[base+i], e[i]);
      end
    end
  endtask

  // lat = count of the falling edge where done is seen, the start-driving edge being 1.
  task automatic run_job(input string tag, input int extra_start_at, output int lat);
    bit seen;
    log_addr.delete();
    log_data.delete();
    done_cnt = 0;
    lat = 0;
    seen = 0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 2; c <= 2000 && !seen; c++) begin
      @(negedge clk);
      start = (c == extra_start_at);
      if (done) begin
        lat = c;
        seen = 1;
      end
    end
    start = 1'b0;
    chk({tag, "_finished"}, 32'(seen), 32'h1);
    repeat (3) @(negedge clk);
  endtask

  task automatic cfg_set(input int m, input int k, input int n, input int a, input int b,
                         input int c, input int d, input logic [31:0] ddr, input int vpu);
    cfg_m = DW'(m); cfg_k = DW'(k); cfg_n = DW'(n);
    cfg_addr_a = AW'(a); cfg_addr_b = AW'(b); cfg_addr_c = AW'(c); cfg_addr_d = AW'(d);
    cfg_addr_ddr = ddr; cfg_vpu_mode = 3'(vpu);
  endtask

  initial begin
    int lat;
    bit reached;
    cfg_lat_c = 16'd7;
    cfg_lat_d = 16'd9;
    cfg_set(4, 4, 4, 8, 16, 24, 32, 32'h1000, 5);
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_wr_en", 32'(cu_csr_wr_en), 0);
    chk("rst_rd_en", 32'(cu_csr_rd_en), 0);
    chk("rst_addr", 32'(cu_csr_addr), 0);
    chk("rst_wdata", cu_csr_wr_data, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single tile: CHECK, CALC, 11 PROG, KICK at edge 15, done bit sampled 20 edges on, NEXT, FINISH.
    resp_lat = 20;
    run_job("t1", 0, lat);
    chk("t1_latency", lat, 36);
    chk("t1_nwrites", log_addr.size(), 12);
    chk_tile("t1", 0, 4, 4, 4, 8, 16, 24, 32, 32'h1000, 5);
    chk("t1_done_pulses", done_cnt, 1);
    chk("t1_err", 32'(err), 0);
    chk("t1_busy_after", 32'(busy), 0);

    // m=6: two M tiles, the second partial.
    resp_lat = 5;
    cfg_set(6, 4, 4, 0, 0, 0, 100, 32'h2000, 5);
    run_job("t2", 0, lat);
    chk("t2_nwrites", log_addr.size(), 24);
    chk_tile("t2a", 0, 4, 4, 4, 0, 0, 0, 100, 32'h2000, 5);
    chk_tile("t2b", 12, 2, 4, 4, 4, 0, 4, 104, 32'h2400, 5);
    chk("t2_err", 32'(err), 0);

    // k=8: second K tile accumulates onto D and carries the VPU mode.
    cfg_set(4, 8, 4, 10, 200, 50, 100, 32'h3000, 3);
    run_job("t3", 0, lat);
    chk("t3_nwrites", log_addr.size(), 24);
    chk_tile("t3a", 0, 4, 4, 4, 10, 200, 50, 100, 32'h3000, 0);
    chk_tile("t3b", 12, 4, 4, 4, 14, 204, 100, 100, 32'h3000, 3);

    // Zero dimension: no CSR traffic, done on the third cycle.
    cfg_set(4, 4, 0, 8, 16, 24, 32, 32'h1000, 5);
    run_job("t4", 0, lat);
    chk("t4_latency", lat, 3);
    chk("t4_nwrites", log_addr.size(), 0);
    chk("t4_err", 32'(err), 1);
    chk("t4_done_pulses", done_cnt, 1);

    // Silent control_unit: 100 WAIT cycles from edge 17, FINISH at edge 117.
    resp_lat = 0;
    cfg_set(4, 4, 4, 8, 16, 24, 32, 32'h1000, 5);
    run_job("t5", 0, lat);
    chk("t5_latency", lat, 117);
    chk("t5_err", 32'(err), 2);
    chk("t5_nwrites", log_addr.size(), 12);
    chk("t5_rd_en_after", 32'(cu_csr_rd_en), 0);

    // Next job clears the sticky timeout error.
    resp_lat = 20;
    run_job("t5b", 0, lat);
    chk("t5b_err", 32'(err), 0);
    chk("t5b_latency", lat, 36);

    // Second start while in WAIT is ignored.
    run_job("t6", 25, lat);
    chk("t6_latency", lat, 36);
    chk("t6_nwrites", log_addr.size(), 12);
    chk("t6_done_pulses", done_cnt, 1);

    // Reset mid-PROG: outputs drop before the next clock edge.
    log_addr.delete();
    log_data.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reached = 0;
    for (int i = 0; i < 50 && !reached; i++) begin
      @(negedge clk);
      if (log_addr.size() >= 3) reached = 1;
    end
    chk("t7_reached_prog", 32'(reached), 1);
    chk("t7_wr_en_before", 32'(cu_csr_wr_en), 1);
    #2 rst = 1'b1;
    #1;
    chk("t7_busy", 32'(busy), 0);
    chk("t7_wr_en", 32'(cu_csr_wr_en), 0);
    chk("t7_addr", 32'(cu_csr_addr), 0);
    chk("t7_wdata", cu_csr_wr_data, 0);
    chk("t7_done", 32'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_job("t8", 0, lat);
    chk("t8_latency", lat, 36);
    chk("t8_nwrites", log_addr.size(), 12);
    chk_tile("t8", 0, 4, 4, 4, 8, 16, 24, 32, 32'h1000, 5);
    chk("t8_err", 32'(err), 0);

    chk("wr_rd_overlap", overlap, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
